reg_read_stage: RTL and testbench
=================================

REG_READ_STAGE -- requirements
Module: reg_read_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32: register and data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5: register address width; 2**ADDR_W registers.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1: decode-stage instruction valid.
REQ-006 SHALL have port rs_addr, input, ADDR_W: source register A address (instr[25:21]).
REQ-007 SHALL have port rt_addr, input, ADDR_W: source register B address (instr[20:16]).
REQ-008 SHALL have port wr_en, input, 1: writeback enable (RegWrite).
REQ-009 SHALL have port wr_addr, input, ADDR_W: writeback destination, the selected WriteReg.
REQ-010 SHALL have port wr_data, input, DATA_W: writeback data.
REQ-011 SHALL have port stall, input, 1: hold the ID/EX output register.
REQ-012 SHALL have port flush, input, 1: squash the ID/EX output register.
REQ-013 SHALL have port out_valid, output, 1: ID/EX entry valid.
REQ-014 SHALL have ports out_rs_data and out_rt_data, output, DATA_W: registered operands.
REQ-015 SHALL have ports out_rs_addr and out_rt_addr, output, ADDR_W: registered source addresses for forwarding logic.

Function
REQ-016 SHALL hold a 2**ADDR_W x DATA_W register array.
REQ-017 SHALL write wr_data to array[wr_addr] on a rising edge when wr_en=1 and wr_addr!=0.
REQ-018 SHALL ignore writes to register 0, and register 0 SHALL always read 0.
REQ-019 SHALL read each source combinationally with same-cycle write bypass: if wr_en=1, wr_addr==src and src!=0, the read value is wr_data; otherwise it is array[src].
REQ-020 SHALL give flush priority over stall: on a rising edge with flush=1, out_valid, out_*_data and out_*_addr SHALL be set to 0.
REQ-021 SHALL hold all outputs on a rising edge with stall=1 and flush=0, except as given in REQ-022.
REQ-022 SHALL, during stall, replace out_rs_data with wr_data when wr_en=1 and wr_addr==out_rs_addr!=0; the same rule SHALL apply to out_rt_data and out_rt_addr, so that a held entry never carries a stale operand.
REQ-023 SHALL, on a rising edge with stall=0 and flush=0, capture in_valid, the bypassed read data and the addresses into the outputs; latency is one cycle.
REQ-024 SHALL capture data regardless of in_valid; out_valid alone qualifies the entry.
REQ-025 SHALL, when rs_addr==rt_addr, apply the bypass to both outputs identically.

Reset
REQ-026 SHALL, while rst_n=0, immediately clear all array entries and all outputs to 0, independent of clk.
REQ-027 SHALL perform no write while rst_n=0, even when wr_en=1; the first write is accepted on the first rising edge after rst_n rises.
REQ-028 SHALL abandon a stalled entry when reset is asserted mid-stall; after release, out_valid=0 until new capture.

Structure
REQ-029 SHALL take DATA_W and ADDR_W defaults and the zero-register index constant from the shared processor package.
REQ-030 SHALL instantiate one sub-module, reg_file_32x32 (array, write port, two bypassed read ports); the pipeline register and stall refresh SHALL reside in reg_read_stage.

Verification
REQ-031 SHALL cover basic write then read: write 0xDEADBEEF to r8, then next cycle rs_addr=8, in_valid=1 -> one cycle later out_rs_data=0xDEADBEEF, out_valid=1.
REQ-032 SHALL cover same-cycle bypass: wr_en=1, wr_addr=5, wr_data=0x12345678, rs_addr=rt_addr=5 -> next edge out_rs_data=out_rt_data=0x12345678.
REQ-033 SHALL cover the zero register: wr_en=1, wr_addr=0, wr_data=0xFFFFFFFF; then read r0 -> out_rs_data=0, including on the bypass cycle.
REQ-034 SHALL cover stall refresh: entry holds out_rs_addr=9 with data 0x1; stall=1 while writing r9=0xAA -> out_rs_data=0xAA, other outputs unchanged.
REQ-035 SHALL cover flush priority: stall=1 and flush=1 on the same edge -> out_valid=0 and all outputs 0.
REQ-036 SHALL cover asynchronous reset: drop rst_n mid-cycle with r3=0x55 and out_valid=1 -> outputs 0 before the next edge; after release, reading r3 returns 0.

Source files
------------

// File: rtl/reg_read_stage_pkg.sv
// Shared processor constants for the decode/register-read stage.
package reg_read_stage_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int ZERO_REG   = 0;
endpackage

// File: rtl/reg_file_32x32.sv
// Register array with one write port and two combinational read ports that
// bypass a same-cycle write; register 0 is hardwired to zero.
module reg_file_32x32
  import reg_read_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data
);
  localparam int NREGS = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  logic [NREGS-1:0][DATA_W-1:0] mem_q;
  logic                         wr_ok;

  assign wr_ok = wr_en && (wr_addr != ZERO_IDX);

  // Entry 0 is cleared by reset and never written, so it always reads 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     mem_q <= '0;
    else if (wr_ok) mem_q[wr_addr] <= wr_data;
  end

  assign ra_data = (wr_ok && wr_addr == ra_addr) ? wr_data : mem_q[ra_addr];
  assign rb_data = (wr_ok && wr_addr == rb_addr) ? wr_data : mem_q[rb_addr];
endmodule

// File: rtl/reg_read_stage.sv
// Register-read stage: register file plus the ID/EX pipeline register with
// flush, stall hold and stall-time operand refresh from writeback.
module reg_read_stage
  import reg_read_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_rs_data,
  output logic [DATA_W-1:0] out_rt_data,
  output logic [ADDR_W-1:0] out_rs_addr,
  output logic [ADDR_W-1:0] out_rt_addr
);
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] rs_rd, rt_rd;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d, rt_data_q, rt_data_d;
  logic [ADDR_W-1:0] rs_addr_q, rs_addr_d, rt_addr_q, rt_addr_d;

  reg_file_32x32 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .ra_addr (rs_addr),
    .rb_addr (rt_addr),
    .ra_data (rs_rd),
    .rb_data (rt_rd)
  );

  always_comb begin
    valid_d   = valid_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    rs_addr_d = rs_addr_q;
    rt_addr_d = rt_addr_q;
    if (flush) begin
      valid_d   = 1'b0;
      rs_data_d = '0;
      rt_data_d = '0;
      rs_addr_d = '0;
      rt_addr_d = '0;
    end else if (stall) begin
      // A held entry snoops writeback so it never carries a stale operand.
      if (wr_en && wr_addr == rs_addr_q && rs_addr_q != ZERO_IDX) rs_data_d = wr_data;
      if (wr_en && wr_addr == rt_addr_q && rt_addr_q != ZERO_IDX) rt_data_d = wr_data;
    end else begin
      valid_d   = in_valid;
      rs_data_d = rs_rd;
      rt_data_d = rt_rd;
      rs_addr_d = rs_addr;
      rt_addr_d = rt_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      rs_addr_q <= '0;
      rt_addr_q <= '0;
    end else begin
      valid_q   <= valid_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      rs_addr_q <= rs_addr_d;
      rt_addr_q <= rt_addr_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_rs_data = rs_data_q;
  assign out_rt_data = rt_data_q;
  assign out_rs_addr = rs_addr_q;
  assign out_rt_addr = rt_addr_q;
endmodule

// File: tb/tb_reg_read_stage.sv
// Scoreboard bench for reg_read_stage: a reference model predicts each ID/EX
// entry when stimulus is applied; entries are popped and compared after the edge.
module tb_reg_read_stage;
  localparam int DW = 32;
  localparam int AW = 5;

  typedef struct packed {
    logic          v;
    logic [DW-1:0] rs_d;
    logic [DW-1:0] rt_d;
    logic [AW-1:0] rs_a;
    logic [AW-1:0] rt_a;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [AW-1:0] rs_addr = '0, rt_addr = '0, wr_addr = '0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          stall = 1'b0, flush = 1'b0;
  logic          out_valid;
  logic [DW-1:0] out_rs_data, out_rt_data;
  logic [AW-1:0] out_rs_addr, out_rt_addr;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mdl [2**AW];
  ent_t          cur;
  ent_t          sb [$];
  ent_t          obs, exp_e;

  always #5 clk = ~clk;

  assign obs = {out_valid, out_rs_data, out_rt_data, out_rs_addr, out_rt_addr};

  reg_read_stage #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .rs_addr     (rs_addr),
    .rt_addr     (rt_addr),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .stall       (stall),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_rs_data (out_rs_data),
    .out_rt_data (out_rt_data),
    .out_rs_addr (out_rs_addr),
    .out_rt_addr (out_rt_addr)
  );

  function automatic logic [DW-1:0] rd(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (wr_en && wr_addr == a) return wr_data;
    return mdl[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2**AW; i++) mdl[i] = '0;
    cur = '0;
    sb.delete();
  endtask

  task automatic idle();
    in_valid = 0; rs_addr = 0; rt_addr = 0;
    wr_en = 0; wr_addr = 0; wr_data = 0; stall = 0; flush = 0;
  endtask

  // Predict the entry for the coming edge, push it, advance the model, clock.
  task automatic tick();
    ent_t nxt;
    if (flush) nxt = '0;
    else if (stall) begin
      nxt = cur;
      if (wr_en && wr_addr == cur.rs_a && cur.rs_a != 0) nxt.rs_d = wr_data;
      if (wr_en && wr_addr == cur.rt_a && cur.rt_a != 0) nxt.rt_d = wr_data;
    end else nxt = '{v: in_valid, rs_d: rd(rs_addr), rt_d: rd(rt_addr), rs_a: rs_addr, rt_a: rt_addr};
    if (wr_en && wr_addr != 0) mdl[wr_addr] = wr_data;
    cur = nxt;
    sb.push_back(nxt);
    @(posedge clk);
    #1;
  endtask

  task automatic pop_exp();
    if (sb.size() == 0) begin
      exp_e = '1;
      errors++;
      $display("FAIL scoreboard_empty");
    end else exp_e = sb.pop_front();
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (obs !== '0) begin
      errors++; $display("FAIL reset_outputs got %h exp 0", obs);
    end
    #11 rst_n = 1;
    @(posedge clk); #1;
    checks++;
    if (obs !== '0) begin
      errors++; $display("FAIL reset_after_release got %h exp 0", obs);
    end
  endtask

  task automatic test_write_read();
    idle(); wr_en = 1; wr_addr = 8; wr_data = 32'hDEADBEEF;
    tick(); pop_exp();
    checks++;
    if (obs !== exp_e) begin
      errors++; $display("FAIL wr_cycle got %h exp %h", obs, exp_e);
    end
    idle(); in_valid = 1; rs_addr = 8;
    tick(); pop_exp();
    checks++;
    if (out_rs_data !== 32'hDEADBEEF || out_valid !== 1'b1) begin
      errors++; $display("FAIL write_read rs %h v %b exp DEADBEEF 1", out_rs_data, out_valid);
    end
    checks++;
    if (obs !== exp_e) begin
      errors++; $display("FAIL write_read_entry got %h exp %h", obs, exp_e);
    end
  endtask

  task automatic test_bypass();
    idle(); in_valid = 1; wr_en = 1; wr_addr = 5; wr_data = 32'h12345678;
    rs_addr = 5; rt_addr = 5;
    tick(); pop_exp();
    checks++;
    if (out_rs_data !== 32'h12345678 || out_rt_data !== 32'h12345678) begin
      errors++; $display("FAIL bypass rs %h rt %h exp 12345678", out_rs_data, out_rt_data);
    end
    checks++;
    if (obs !== exp_e) begin
      errors++; $display("FAIL bypass_entry got %h exp %h", obs, exp_e);
    end
  endtask

  task automatic test_zero_reg();
    idle(); in_valid = 1; wr_en = 1; wr_addr = 0; wr_data = 32'hFFFFFFFF;
    rs_addr = 0; rt_addr = 0;
    tick(); pop_exp();
    checks++;
    if (out_rs_data !== '0 || out_rt_data !== '0) begin
      errors++; $display("FAIL zero_bypass rs %h rt %h exp 0", out_rs_data, out_rt_data);
    end
    idle(); in_valid = 1;
    tick(); pop_exp();
    checks++;
    if (out_rs_data !== '0 || obs !== exp_e) begin
      errors++; $display("FAIL zero_read got %h exp %h", obs, exp_e);
    end
  endtask

  task automatic test_stall_refresh();
    idle(); wr_en = 1; wr_addr = 9; wr_data = 32'h1;
    tick(); pop_exp();
    idle(); in_valid = 1; rs_addr = 9; rt_addr = 8;
    tick(); pop_exp();
    checks++;
    if (out_rs_data !== 32'h1 || out_rs_addr !== 5'd9) begin
      errors++; $display("FAIL stall_setup rs %h a %0d exp 1 9", out_rs_data, out_rs_addr);
    end
    idle(); stall = 1; wr_en = 1; wr_addr = 9; wr_data = 32'hAA; rs_addr = 3; rt_addr = 4;
    tick(); pop_exp();
    checks++;
    if (out_rs_data !== 32'hAA || out_valid !== 1'b1 || out_rs_addr !== 5'd9 ||
        out_rt_data !== 32'hDEADBEEF || out_rt_addr !== 5'd8) begin
      errors++; $display("FAIL stall_refresh got %h exp rs=AA", obs);
    end
    idle(); stall = 1; in_valid = 1; rs_addr = 1;
    tick(); pop_exp();
    checks++;
    if (obs !== exp_e) begin
      errors++; $display("FAIL stall_hold got %h exp %h", obs, exp_e);
    end
  endtask

  task automatic test_flush();
    idle(); stall = 1; flush = 1; in_valid = 1; rs_addr = 8;
    tick(); pop_exp();
    checks++;
    if (obs !== '0) begin
      errors++; $display("FAIL flush_priority got %h exp 0", obs);
    end
  endtask

  task automatic test_async_reset();
    idle(); wr_en = 1; wr_addr = 3; wr_data = 32'h55;
    tick(); pop_exp();
    idle(); in_valid = 1; rs_addr = 3;
    tick(); pop_exp();
    checks++;
    if (out_valid !== 1'b1 || out_rs_data !== 32'h55) begin
      errors++; $display("FAIL ares_setup v %b rs %h exp 1 55", out_valid, out_rs_data);
    end
    #3 rst_n = 0;
    #1;
    checks++;
    if (obs !== '0) begin
      errors++; $display("FAIL ares_immediate got %h exp 0", obs);
    end
    model_clear();
    wr_en = 1; wr_addr = 3; wr_data = 32'h77;
    @(posedge clk); #1;
    #2 rst_n = 1;
    idle();
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL ares_release_valid got %b exp 0", out_valid);
    end
    in_valid = 1; rs_addr = 3;
    tick(); pop_exp();
    checks++;
    if (out_rs_data !== '0 || obs !== exp_e) begin
      errors++; $display("FAIL ares_r3_cleared got %h exp %h", obs, exp_e);
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 40; n++) begin
      in_valid = 1'($urandom);
      rs_addr  = AW'($urandom_range(0, 7));
      rt_addr  = AW'($urandom_range(0, 7));
      wr_en    = 1'($urandom);
      wr_addr  = AW'($urandom_range(0, 7));
      wr_data  = $urandom;
      stall    = ($urandom_range(0, 3) == 0);
      flush    = ($urandom_range(0, 7) == 0);
      tick(); pop_exp();
      checks++;
      if (obs !== exp_e) begin
        errors++; $display("FAIL b2b_%0d got %h exp %h", n, obs, exp_e);
      end
    end
    idle();
  endtask

  initial begin
    model_clear();
    idle();
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_stall_refresh();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
